// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the execute stage, the load/store controller and the
// word-organised data memory. The slave modport is the controller's view;
// the master modport is the requester plus memory side.
interface dmem_access_ctrl_if #(
  parameter int AW = 11
);
  // CPU request/response side
  logic          req;
  logic [2:0]    op;
  logic [AW+1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          addr_err;
  // data memory side
  logic [AW-1:0] dm_addr;
  logic          dm_cs;
  logic          dm_r;
  logic          dm_w;
  logic          dm_sb;
  logic          dm_sh;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  modport slave (
    input  req, op, addr, wdata, dm_rdata,
    output ready, done, rdata, addr_err,
    output dm_addr, dm_cs, dm_r, dm_w, dm_sb, dm_sh, dm_wdata
  );

  modport master (
    output req, op, addr, wdata, dm_rdata,
    input  ready, done, rdata, addr_err,
    input  dm_addr, dm_cs, dm_r, dm_w, dm_sb, dm_sh, dm_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store controller: byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests
// mapped onto a word memory whose SB/SH strobes only reach lane 0. Sub-word
// stores to other lanes are done as read-modify-write; misaligned requests
// complete with addr_err and never touch memory.
module dmem_access_ctrl #(
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    r_op;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_done;
  logic          r_addr_err;

  logic [2:0]    w_next_state;
  logic          w_misaligned;
  logic [31:0]   w_load_val;
  logic [31:0]   w_merge;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // Alignment check on the incoming (not yet latched) request
  always_comb begin
    w_misaligned = 1'b0;
    if ((bus.op == OP_LW || bus.op == OP_SW) && bus.addr[1:0] != 2'b00)
      w_misaligned = 1'b1;
    if ((bus.op == OP_LH || bus.op == OP_LHU || bus.op == OP_SH) && bus.addr[0])
      w_misaligned = 1'b1;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_misaligned)
            w_next_state = S_ERR;
          else if (bus.op <= OP_LW)
            w_next_state = S_LD;
          else if (bus.op == OP_SW || bus.addr[1:0] == 2'b00)
            w_next_state = S_WR;
          else
            w_next_state = S_RMW_RD;
        end
      end
      S_LD:     w_next_state = S_RESP;
      S_WR:     w_next_state = S_RESP;
      S_RMW_RD: w_next_state = S_RMW_WR;
      S_RMW_WR: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      S_ERR:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Lane selection and sign/zero extension of the word being read
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.dm_rdata[7:0];
      2'd1:    w_byte = bus.dm_rdata[15:8];
      2'd2:    w_byte = bus.dm_rdata[23:16];
      default: w_byte = bus.dm_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    case (r_op)
      OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_val = {24'd0, w_byte};
      OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_val = {16'd0, w_half};
      default: w_load_val = bus.dm_rdata;
    endcase
  end

  // Per-lane merge: replace the target byte (SB) or upper halfword (SH)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic w_sb_hit;
      logic w_sh_hit;
      assign w_sb_hit = (r_op == OP_SB) && (r_addr[1:0] == 2'(gi));
      if (gi >= 2) begin : g_hi
        assign w_sh_hit = (r_op == OP_SH);
        assign w_merge[8*gi +: 8] = w_sb_hit ? r_wdata[7:0] :
                                    w_sh_hit ? r_wdata[8*(gi-2) +: 8] :
                                               r_merge[8*gi +: 8];
      end else begin : g_lo
        assign w_sh_hit = 1'b0;
        assign w_merge[8*gi +: 8] = (w_sb_hit || w_sh_hit) ? r_wdata[7:0] :
                                                             r_merge[8*gi +: 8];
      end
    end
  endgenerate

  // State, request latch, load result and response flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_merge    <= 32'd0;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_done     <= (w_next_state == S_RESP) || (w_next_state == S_ERR);
      r_addr_err <= (w_next_state == S_ERR);
      if (r_state == S_IDLE && bus.req) begin
        r_op    <= bus.op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (r_state == S_LD)
        r_rdata <= w_load_val;
      if (r_state == S_RMW_RD)
        r_merge <= bus.dm_rdata;
    end
  end

  // Memory strobes are gated by rst_n so a write in flight is never committed
  assign bus.dm_cs    = rst_n && (r_state == S_LD || r_state == S_WR ||
                                  r_state == S_RMW_RD || r_state == S_RMW_WR);
  assign bus.dm_r     = rst_n && (r_state == S_LD || r_state == S_RMW_RD);
  assign bus.dm_w     = rst_n && (r_state == S_WR || r_state == S_RMW_WR);
  assign bus.dm_sb    = rst_n && (r_state == S_WR) && (r_op == OP_SB);
  assign bus.dm_sh    = rst_n && (r_state == S_WR) && (r_op == OP_SH);
  assign bus.dm_addr  = bus.dm_cs ? r_addr[AW+1:2] : '0;
  assign bus.dm_wdata = (r_state == S_RMW_WR) ? w_merge : r_wdata;

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.done     = r_done;
  assign bus.addr_err = r_addr_err;
  assign bus.rdata    = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a table of single requests with
// hand-computed results, then hand-written reset-abort and throughput cases.
module tb_dmem_access_ctrl;

  localparam int AW = 11;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LBU = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LW  = 3'b100;
  localparam logic [2:0] SB  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SW  = 3'b111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:(1<<AW)-1];

  dmem_access_ctrl_if #(.AW(AW)) bus ();

  dmem_access_ctrl #(.AW(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word memory: async read, posedge write, SB/SH act on lane 0 only
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) begin
    if (bus.dm_cs && bus.dm_w) begin
      if (bus.dm_sb)      mem[bus.dm_addr][7:0]  <= bus.dm_wdata[7:0];
      else if (bus.dm_sh) mem[bus.dm_addr][15:0] <= bus.dm_wdata[15:0];
      else                mem[bus.dm_addr]       <= bus.dm_wdata;
    end
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_cs;
    logic [1:0]    exp_str;   // {sh, sb} seen on the write cycle
    logic [31:0]   exp_wd;    // word written (stores only)
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Issue one request from an idle controller and observe it to completion.
  task automatic do_req(input logic [2:0] op, input logic [AW+1:0] addr,
                        input logic [31:0] wdata,
                        output int lat, output int cs_cnt,
                        output logic [31:0] wd, output logic [1:0] str,
                        output logic [AW-1:0] wa, output logic err,
                        output logic [31:0] rd);
    lat = 0; cs_cnt = 0; wd = 32'h0; str = 2'b00; wa = '0; err = 1'b0; rd = 32'h0;
    @(negedge clk);
    bus.op = op; bus.addr = addr; bus.wdata = wdata; bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.dm_cs) cs_cnt++;
      if (bus.dm_cs && bus.dm_w) begin
        wd = bus.dm_wdata; str = {bus.dm_sh, bus.dm_sb}; wa = bus.dm_addr;
      end
      if (bus.done) begin
        lat = c; err = bus.addr_err; rd = bus.rdata;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'(lat), 32'd1);
  endtask

  int            lat, cs_cnt, acc, nd;
  logic [31:0]   wd, rd;
  logic [1:0]    str;
  logic [AW-1:0] wa;
  logic          err;
  int            dtimes [4];

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    bus.req = 1'b0; bus.op = 3'd0; bus.addr = '0; bus.wdata = 32'h0;

    //              op   addr      wdata         rdata        err  lat cs str    wd
    vec[0]  = '{SW,  13'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 2'b00, 32'hDEADBEEF};
    vec[1]  = '{LW,  13'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[2]  = '{SW,  13'h010, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 2, 1, 2'b00, 32'h80FF7F01};
    vec[3]  = '{LB,  13'h010, 32'h0,        32'h00000001, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[4]  = '{LB,  13'h011, 32'h0,        32'h0000007F, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[5]  = '{LB,  13'h012, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[6]  = '{LB,  13'h013, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[7]  = '{LBU, 13'h013, 32'h0,        32'h00000080, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[8]  = '{LH,  13'h012, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[9]  = '{LHU, 13'h012, 32'h0,        32'h000080FF, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[10] = '{SW,  13'h010, 32'h11223344, 32'h000080FF, 1'b0, 2, 1, 2'b00, 32'h11223344};
    vec[11] = '{SB,  13'h012, 32'h000000AB, 32'h000080FF, 1'b0, 3, 2, 2'b00, 32'h11AB3344};
    vec[12] = '{SH,  13'h010, 32'h0000CAFE, 32'h000080FF, 1'b0, 2, 1, 2'b10, 32'h0000CAFE};
    vec[13] = '{LW,  13'h010, 32'h0,        32'h11ABCAFE, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[14] = '{SH,  13'h012, 32'h0000BEEF, 32'h11ABCAFE, 1'b0, 3, 2, 2'b00, 32'hBEEFCAFE};
    vec[15] = '{LW,  13'h010, 32'h0,        32'hBEEFCAFE, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[16] = '{LW,  13'h011, 32'h0,        32'hBEEFCAFE, 1'b1, 1, 0, 2'b00, 32'h0};
    vec[17] = '{SW,  13'h012, 32'h0,        32'hBEEFCAFE, 1'b1, 1, 0, 2'b00, 32'h0};
    vec[18] = '{LH,  13'h013, 32'h0,        32'hBEEFCAFE, 1'b1, 1, 0, 2'b00, 32'h0};
    vec[19] = '{LW,  13'h010, 32'h0,        32'hBEEFCAFE, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[20] = '{LH,  13'h010, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[21] = '{SB,  13'h013, 32'h00000012, 32'hFFFFCAFE, 1'b0, 3, 2, 2'b00, 32'h12EFCAFE};
    vec[22] = '{LW,  13'h010, 32'h0,        32'h12EFCAFE, 1'b0, 2, 1, 2'b00, 32'h0};
    vec[23] = '{SW,  13'h1FFC, 32'hA5A5A5A5, 32'h12EFCAFE, 1'b0, 2, 1, 2'b00, 32'hA5A5A5A5};
    vec[24] = '{LW,  13'h1FFC, 32'h0,       32'hA5A5A5A5, 1'b0, 2, 1, 2'b00, 32'h0};

    // reset: strobes gated while low, clean response state afterwards
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dm_cs", 32'(bus.dm_cs), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_addr_err", 32'(bus.addr_err), 32'd0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_req(vec[i].op, vec[i].addr, vec[i].wdata, lat, cs_cnt, wd, str, wa, err, rd);
      $display("vec %0d op=%0d addr=%04h wdata=%08h -> lat=%0d err=%0d rdata=%08h cs=%0d",
               i, vec[i].op, vec[i].addr, vec[i].wdata, lat, err, rd, cs_cnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vec[i].exp_lat));
      chk($sformatf("v%0d_addr_err", i), 32'(err), 32'(vec[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
      chk($sformatf("v%0d_cs_cycles", i), 32'(cs_cnt), 32'(vec[i].exp_cs));
      if (vec[i].op >= SB && !vec[i].exp_err) begin
        chk($sformatf("v%0d_dm_wdata", i), wd, vec[i].exp_wd);
        chk($sformatf("v%0d_strobes", i), 32'(str), 32'(vec[i].exp_str));
        chk($sformatf("v%0d_dm_addr", i), 32'(wa), 32'(vec[i].addr[AW+1:2]));
      end
    end

    // reset during RMW_WR: write must be suppressed and no done produced
    do_req(SW, 13'h020, 32'h12345678, lat, cs_cnt, wd, str, wa, err, rd);
    @(negedge clk);
    bus.op = SB; bus.addr = 13'h021; bus.wdata = 32'h55; bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("abort_rmw_rd_dm_r", 32'(bus.dm_r), 32'd1);
    @(negedge clk);
    chk("abort_rmw_wr_dm_w_before", 32'(bus.dm_w), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_dm_w_gated", 32'(bus.dm_w), 32'd0);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready_next", 32'(bus.ready), 32'd1);
    chk("abort_done_low", 32'(bus.done), 32'd0);
    $display("abort SB 0021 by reset: ready=%0d done=%0d", bus.ready, bus.done);
    do_req(LW, 13'h020, 32'h0, lat, cs_cnt, wd, str, wa, err, rd);
    $display("LW 0020 after abort -> rdata=%08h", rd);
    chk("abort_word_intact", rd, 32'h12345678);

    // req held high: accepted only in IDLE, done every third cycle
    acc = 0; nd = 0;
    @(negedge clk);
    bus.op = LW; bus.addr = 13'h010; bus.req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.ready && bus.req) acc++;
      if (bus.done) begin
        if (nd < 4) dtimes[nd] = i;
        nd++;
      end
      if (i == 7) bus.req = 1'b0;
    end
    $display("held req: accepts=%0d dones=%0d", acc, nd);
    chk("held_accepts", 32'(acc), 32'd3);
    chk("held_done_count", 32'(nd), 32'd3);
    if (nd >= 3) begin
      chk("held_gap1", 32'(dtimes[1] - dtimes[0]), 32'd3);
      chk("held_gap2", 32'(dtimes[2] - dtimes[1]), 32'd3);
    end

    // a req pulse while busy must be dropped
    nd = 0;
    @(negedge clk);
    bus.op = LW; bus.addr = 13'h020; bus.req = 1'b1;
    @(negedge clk);
    chk("busy_ready_low", 32'(bus.ready), 32'd0);
    bus.op = SW; bus.addr = 13'h020; bus.wdata = 32'hFFFFFFFF;
    @(negedge clk);
    if (bus.done) nd++;
    bus.req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    $display("busy pulse: dones=%0d word8=%08h", nd, mem[8]);
    chk("busy_done_count", 32'(nd), 32'd1);
    chk("busy_mem_unchanged", mem[8], 32'h12345678);
    chk("busy_rdata", bus.rdata, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store controller between the CPU execute stage and the word-organised data memory (11-bit word address, async read, posedge write, low-lane-only SB/SH strobes).
- Takes byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests and returns sign- or zero-extended load data.
- Writes bytes and halfwords to any lane: native strobes when the lane is 0, read-modify-write otherwise.
- Flags misaligned accesses without touching memory.

Parameters:
- AW, 11, word-address width driven to the data memory; byte address width is AW+2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  1  request valid, sampled only when ready=1
- op  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addr  input  AW+2  byte address
- wdata  input  32  store data, value right-aligned
- ready  output  1  controller idle, can accept req
- done  output  1  one-cycle completion pulse
- rdata  output  32  load result, valid when done=1 and the op is a load
- addr_err  output  1  with done: misaligned request, no memory access
- dm_addr  output  AW  word address to the data memory
- dm_cs, dm_r, dm_w, dm_sb, dm_sh  output  1 each  data-memory strobes
- dm_wdata  output  32  word to the data memory write port
- dm_rdata  input  32  data-memory read data, combinational from dm_addr

Behaviour:
- Reset
  - rst_n low at an edge puts the controller in IDLE, regardless of current state.
  - Registered outputs clear: done=0, addr_err=0, rdata=0.
  - ready=1 from the next cycle.
  - All dm_* strobes are gated with rst_n and are 0 in any cycle where rst_n=0, so an in-flight write is never committed.
- States: IDLE, LD, WR, RMW_RD, RMW_WR, RESP, ERR.
- IDLE: ready=1, strobes 0. On req=1, latch op, addr and wdata, then go to:
  - ERR if misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - LD for any load.
  - WR for SW, SB with addr[1:0]=0, or SH with addr[1:0]=0.
  - RMW_RD for SB with addr[1:0]!=0, or SH with addr[1:0]=2.
- LD: dm_cs=dm_r=1. Capture the extracted value into rdata at the edge, then go to RESP.
- WR: dm_cs=dm_w=1.
  - dm_sb=1 for SB, dm_sh=1 for SH.
  - dm_wdata = latched wdata.
  - Next state RESP.
- RMW_RD: dm_cs=dm_r=1. Capture dm_rdata into an internal merge register, then go to RMW_WR.
- RMW_WR: dm_cs=dm_w=1, dm_sb=dm_sh=0. dm_wdata is the merge register with the target lane replaced:
  - byte lane k uses bits [8k+7:8k] from wdata[7:0];
  - halfword lane 1 uses bits [31:16] from wdata[15:0].
  - Next state RESP.
- RESP: done=1 for one cycle, addr_err=0, then IDLE.
- ERR: done=1, addr_err=1 for one cycle, no strobe ever asserted, then IDLE. rdata is unchanged.
- Addressing and lanes:
  - dm_addr = latched addr[AW+1:2] whenever dm_cs=1, else 0.
  - Little-endian: byte offset 0 is bits [7:0].
- Load extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- rdata holds its value until the next load completes; stores do not alter it.
- Latency from the req-accept edge to done:
  - 2 cycles: loads, SW, lane-0 SB/SH.
  - 3 cycles: RMW stores.
  - 1 cycle: misaligned requests.
- req is ignored while ready=0; there is no queuing. The requester holds req until it sees ready.
- Back-to-back: a req sampled in the IDLE cycle right after RESP starts immediately.
- Address wrap: the top word address is legal; there is no wrap or bounds check.

Test Plan:
- Reset then aligned store-load:
  - SW addr=0x010 wdata=0xDEADBEEF: WR asserts dm_w with dm_addr=4; done 2 cycles after accept.
  - LW addr=0x010: rdata=0xDEADBEEF, addr_err=0.
- Byte lanes and extension:
  - Memory word 4 = 0x80FF7F01.
  - LB at 0x010..0x013 gives 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU at 0x013 gives 0x00000080.
  - LH at 0x012 gives 0xFFFF80FF; LHU at 0x012 gives 0x000080FF.
- Sub-word stores on word 4 = 0x11223344:
  - SB 0x012 wdata=0xAB: RMW_RD then RMW_WR, dm_wdata=0x11AB3344, done 3 cycles after accept.
  - SH 0x010 wdata=0xCAFE: single WR cycle with dm_sh=1, word becomes 0x11ABCAFE.
  - SH 0x012 wdata=0xBEEF: RMW, word becomes 0xBEEFCAFE.
- Misalignment:
  - LW 0x011, SW 0x012 and LH 0x013 each give done=addr_err=1 one cycle after accept, dm_cs never 1.
  - Memory is unchanged and rdata keeps its previous value.
- Reset mid-operation:
  - Issue SB 0x021 wdata=0x55 and drop rst_n in the RMW_WR cycle: dm_w=0 that cycle, no done.
  - Next cycle ready=1; LW 0x020 returns the original word.
- Throughput and busy handling:
  - req held high for 3 consecutive LW ops: each accepted only in IDLE.
  - done pulses arrive exactly 3 cycles apart; a req pulse while ready=0 is dropped.
